// File: rtl/spi_config_pkg.sv
// Shared definitions for the SPI configuration master.
// Contents:
//   - master FSM state type
//   - default frame length
//   - byte offsets of each field in the configuration frame, for use by the harness
package spi_config_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    FETCH,
    SHIFT,
    TAIL,
    GUARD
  } state_t;

  localparam int unsigned FRAME_BYTES_DEFAULT = 215;

  // Frame layout. Byte 0 is shifted first.
  localparam int unsigned OFS_INPUT_SPIKES   = 0;    // bytes 0..2
  localparam int unsigned INPUT_SPIKE_BYTES  = 3;
  localparam int unsigned OFS_NEURON_PARAMS  = 3;    // decay/refractory/threshold, bytes 3..4
  localparam int unsigned NEURON_PARAM_BYTES = 2;
  localparam int unsigned OFS_DIV_VALUE      = 5;
  localparam int unsigned OFS_WEIGHTS        = 6;
  localparam int unsigned WEIGHT_BYTES       = 104;
  localparam int unsigned OFS_DELAYS         = 110;
  localparam int unsigned DELAY_BYTES        = 104;
  localparam int unsigned OFS_DEBUG_CONFIG   = 214;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: a registered SPI clock that idles low.
// Each half-period lasts HALF_DIV cycles of clk. While en is high, the counter runs
// and reloads whenever SCLK toggles. While en is low, SCLK is held low and the counter
// is cleared, so the first rise comes HALF_DIV cycles after en goes high.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high
//   en     in   run the clock
//   sclk   out  registered SPI clock
//   rise   out  strobe: SCLK goes high on the next edge
//   fall   out  strobe: SCLK goes low on the next edge
module spi_sclk_gen #(
  parameter int unsigned HALF_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [CW-1:0] hcnt;
  logic          wrap;

  assign wrap = en && (hcnt == CW'(HALF_DIV - 1));
  assign rise = wrap && !sclk;
  assign fall = wrap && sclk;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      hcnt <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      hcnt <= '0;
      sclk <= ~sclk;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_config_master.sv
// SPI mode-0 initiator. It streams one configuration frame, supplied through a
// ready/valid byte source, into the chip's SPI slave. It also captures MISO one byte
// at a time so the harness can check readback.
// Ports:
//   system_clock, reset (synchronous, active-high)
//   start/abort                    frame control pulses
//   byte_data/byte_valid/byte_ready  frame byte source
//   SCLK/MOSI/SS/MISO              SPI bus (mode 0, MSB first, SS active low)
//   rx_byte/rx_valid               last byte captured from MISO
//   busy/done                      frame status
// GUARD_CLKS must be at least 1.
module spi_config_master
  import spi_config_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEFAULT,
  parameter int unsigned HALF_DIV    = 4,
  parameter int unsigned TAIL_CLKS   = 2,
  parameter int unsigned GUARD_CLKS  = 4
) (
  input  logic       system_clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       SCLK,
  output logic       MOSI,
  output logic       SS,
  input  logic       MISO,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BCW = $clog2(FRAME_BYTES + 1);
  localparam int unsigned WCW = 16;

  state_t         state, next_state;
  logic [WCW-1:0] wait_cnt;
  logic [BCW-1:0] byte_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     tx_sr, rx_sr;
  logic           miso_q;
  logic           sclk_en, sclk_rise, sclk_fall;
  logic           kill, handshake, byte_last, setup_done, tail_done, guard_done;

  // An abort in IDLE only suppresses a start. In any other state it ends the frame.
  assign kill       = abort && (state != IDLE);
  // byte_ready is gated by abort so that an abort and a handshake in the same cycle
  // never consume a byte.
  assign byte_ready = (state == FETCH) && !abort;
  assign handshake  = byte_ready && byte_valid;
  assign sclk_en    = ((state == SHIFT) || (state == TAIL)) && !abort;
  assign byte_last  = sclk_fall && (bit_cnt == 3'd7);
  assign setup_done = (wait_cnt == WCW'(HALF_DIV - 1));
  assign tail_done  = sclk_fall && (wait_cnt == WCW'(TAIL_CLKS - 1));
  assign guard_done = (wait_cnt == WCW'(GUARD_CLKS - 1));

  assign busy = (state != IDLE);
  assign SS   = !(state inside {SETUP, FETCH, SHIFT, TAIL});
  assign MOSI = tx_sr[7];

  spi_sclk_gen #(.HALF_DIV(HALF_DIV)) u_sclk (
    .clk   (system_clock),
    .reset (reset),
    .en    (sclk_en),
    .sclk  (SCLK),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  always_ff @(posedge system_clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (kill) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:  if (start && !abort) next_state = SETUP;
        SETUP: if (setup_done) next_state = FETCH;
        FETCH: if (handshake) next_state = SHIFT;
        SHIFT: if (byte_last) begin
          if (byte_cnt == BCW'(FRAME_BYTES - 1))
            next_state = (TAIL_CLKS == 0) ? GUARD : TAIL;
          else
            next_state = FETCH;
        end
        TAIL:  if (tail_done) next_state = GUARD;
        GUARD: if (guard_done) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      wait_cnt <= '0;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      miso_q   <= 1'b0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      done     <= 1'b0;
      miso_q   <= MISO;
      if (kill) begin
        wait_cnt <= '0;
        byte_cnt <= '0;
        bit_cnt  <= '0;
        tx_sr    <= '0;
      end else begin
        case (state)
          IDLE: begin
            wait_cnt <= '0;
            byte_cnt <= '0;
            bit_cnt  <= '0;
          end
          SETUP: wait_cnt <= setup_done ? '0 : wait_cnt + 1'b1;
          FETCH: if (handshake) begin
            tx_sr   <= byte_data;
            bit_cnt <= '0;
          end
          SHIFT: begin
            if (sclk_rise) rx_sr <= {rx_sr[6:0], miso_q};
            if (sclk_fall) begin
              // The shift fills with zero, so MOSI is already low when TAIL begins.
              tx_sr   <= {tx_sr[6:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end
            if (byte_last) begin
              rx_byte  <= rx_sr;
              rx_valid <= 1'b1;
              byte_cnt <= byte_cnt + 1'b1;
              wait_cnt <= '0;
            end
          end
          TAIL: begin
            tx_sr <= '0;
            if (sclk_fall) wait_cnt <= tail_done ? '0 : wait_cnt + 1'b1;
          end
          GUARD: begin
            if (guard_done) begin
              done     <= 1'b1;
              wait_cnt <= '0;
              byte_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          default: wait_cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_config_master.sv
module tb_spi_config_master;

  localparam int unsigned FB = 3;
  localparam int unsigned HD = 2;
  localparam int unsigned TC = 2;
  localparam int unsigned GC = 4;

  logic       system_clock = 1'b0;
  logic       reset, start, abort, byte_valid, MISO;
  logic [7:0] byte_data;
  logic       byte_ready, SCLK, MOSI, SS, rx_valid, busy, done;
  logic [7:0] rx_byte;

  int total = 0;
  int bad   = 0;

  always #5 system_clock = ~system_clock;

  spi_config_master #(
    .FRAME_BYTES (FB),
    .HALF_DIV    (HD),
    .TAIL_CLKS   (TC),
    .GUARD_CLKS  (GC)
  ) dut (
    .system_clock (system_clock),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .SS           (SS),
    .MISO         (MISO),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .busy         (busy),
    .done         (done)
  );

  // Bus observations, sampled on the falling system clock edge
  int         cyc = 0;
  int         rise_cyc[$];
  bit         rise_bits[$];
  logic [7:0] rx_q[$];
  logic [7:0] hs_q[$];
  int         ss_bad = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         ss_rise_cyc = 0;
  logic       sclk_pm = 1'b0;
  logic       ss_pm = 1'b1;

  initial begin
    forever begin
      @(negedge system_clock);
      cyc++;
      if (SCLK === 1'b1 && sclk_pm === 1'b0) begin
        rise_cyc.push_back(cyc);
        rise_bits.push_back(MOSI);
        if (SS !== 1'b0) ss_bad++;
      end
      sclk_pm = SCLK;
      if (SS === 1'b1 && ss_pm === 1'b0) ss_rise_cyc = cyc;
      ss_pm = SS;
      if (rx_valid === 1'b1) rx_q.push_back(rx_byte);
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (byte_ready === 1'b1 && byte_valid === 1'b1) hs_q.push_back(byte_data);
    end
  end

  // SPI slave: samples MOSI on SCLK rise and echoes the previous byte on MISO
  logic       ss_ps = 1'b1, sclk_ps = 1'b0;
  int         s_cnt = 0;
  logic [7:0] s_rx = '0, s_tx = '0, s_last = '0;

  initial begin
    MISO = 1'b0;
    forever begin
      @(SS or SCLK);
      if (SS === 1'b0 && ss_ps === 1'b1) begin
        s_cnt = 0;
        s_tx  = '0;
        MISO  = 1'b0;
      end
      if (SS === 1'b0 && SCLK === 1'b1 && sclk_ps === 1'b0) begin
        s_rx = {s_rx[6:0], MOSI};
        s_cnt++;
        if (s_cnt % 8 == 0) s_last = s_rx;
      end
      if (SS === 1'b0 && SCLK === 1'b0 && sclk_ps === 1'b1) begin
        if (s_cnt % 8 == 0) s_tx = s_last;
        else                s_tx = {s_tx[6:0], 1'b0};
        MISO = s_tx[7];
      end
      ss_ps   = SS;
      sclk_ps = SCLK;
    end
  end

  logic [7:0] fb[FB];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge system_clock);
    #1;
  endtask

  task automatic clear_obs();
    rise_cyc.delete();
    rise_bits.delete();
    rx_q.delete();
    hs_q.delete();
    ss_bad   = 0;
    done_cnt = 0;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("ss_after_start", SS, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    byte_data  = d;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check("ready_timeout", byte_ready, 1'b1);
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 500) begin
      tick();
      n++;
    end
    repeat (5) tick();
    check("done_pulses", done_cnt, 1);
    check("busy_after_done", busy, 1'b0);
    check("ss_after_done", SS, 1'b1);
  endtask

  // Reference model: expected bus activity for the bytes in fb[]
  task automatic verify_frame();
    logic [31:0] obs_vec = '0;
    logic [31:0] exp_vec = '0;
    int          gap_bad = 0;
    logic [7:0]  b;
    for (int i = 0; i < FB; i++) begin
      b = fb[i];
      for (int k = 7; k >= 0; k--) exp_vec = {exp_vec[30:0], b[k]};
    end
    for (int t = 0; t < TC; t++) exp_vec = {exp_vec[30:0], 1'b0};
    for (int i = 0; i < rise_bits.size(); i++) obs_vec = {obs_vec[30:0], rise_bits[i]};
    check("sclk_rises", rise_bits.size(), FB * 8 + TC);
    check("mosi_stream", obs_vec, exp_vec);
    check("ss_low_at_rises", ss_bad, 0);
    for (int i = 1; i < rise_cyc.size(); i++) begin
      if (!((i % 8 == 0) && (i < FB * 8)) && (rise_cyc[i] - rise_cyc[i-1] != 2 * HD)) gap_bad++;
    end
    check("sclk_period", gap_bad, 0);
    check("rx_count", rx_q.size(), FB);
    for (int i = 0; i < FB && i < rx_q.size(); i++)
      check($sformatf("rx_byte%0d", i), rx_q[i], (i == 0) ? 8'h00 : fb[i-1]);
    check("bytes_consumed", hs_q.size(), FB);
    for (int i = 0; i < FB && i < hs_q.size(); i++)
      check($sformatf("consumed%0d", i), hs_q[i], fb[i]);
    check("guard_len", done_cyc - ss_rise_cyc, GC);
  endtask

  task automatic run_frame(input int stall_idx, input bit repulse);
    int stall_bad = 0;
    int n = 0;
    clear_obs();
    for (int i = 0; i < FB; i++) fb[i] = 8'($urandom);
    start_frame();
    for (int i = 0; i < FB; i++) begin
      if (i == stall_idx) begin
        byte_valid = 1'b0;
        while (byte_ready !== 1'b1 && n < 2000) begin
          tick();
          n++;
        end
        repeat (20) begin
          tick();
          if (SCLK !== 1'b0 || SS !== 1'b0 || byte_ready !== 1'b1) stall_bad++;
        end
        check("stall_hold", stall_bad, 0);
      end
      if (repulse && i == 1) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      send_byte(fb[i]);
    end
    wait_done();
    verify_frame();
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = '0;
    repeat (3) tick();
    check("rst_sclk", SCLK, 1'b0);
    check("rst_mosi", MOSI, 1'b0);
    check("rst_ss", SS, 1'b1);
    check("rst_ready", byte_ready, 1'b0);
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b0;
    tick();

    // Fixed bytes A5, 3C, FF
    clear_obs();
    fb[0] = 8'hA5;
    fb[1] = 8'h3C;
    fb[2] = 8'hFF;
    start_frame();
    for (int i = 0; i < FB; i++) send_byte(fb[i]);
    wait_done();
    verify_frame();

    // Random frames, a stalled source, and a re-pulsed start
    run_frame(-1, 1'b0);
    run_frame(2, 1'b0);
    run_frame(-1, 1'b1);

    // start and abort in the same cycle while idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 1'b0);
    check("start_abort_ss", SS, 1'b1);
    repeat (4) tick();
    check("start_abort_idle", busy, 1'b0);

    // abort during bit 4 of byte 1
    clear_obs();
    start_frame();
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    n = 0;
    while (rise_cyc.size() < 13 && n < 1000) begin
      tick();
      n++;
    end
    check("abort_reach_bit4", rise_cyc.size(), 13);
    abort      = 1'b1;
    byte_valid = 1'b1;
    tick();
    abort      = 1'b0;
    byte_valid = 1'b0;
    check("abort_ss", SS, 1'b1);
    check("abort_sclk", SCLK, 1'b0);
    check("abort_mosi", MOSI, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", byte_ready, 1'b0);
    repeat (30) tick();
    check("abort_no_done", done_cnt, 0);
    check("abort_rx_count", rx_q.size(), 1);
    check("abort_consumed", hs_q.size(), 2);
    run_frame(-1, 1'b0);

    // reset during a frame
    clear_obs();
    start_frame();
    send_byte(8'($urandom));
    n = 0;
    while (rise_cyc.size() < 4 && n < 1000) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tick();
    check("midrst_ss", SS, 1'b1);
    check("midrst_sclk", SCLK, 1'b0);
    check("midrst_mosi", MOSI, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", byte_ready, 1'b0);
    check("midrst_rx_byte", rx_byte, 8'h00);
    reset = 1'b0;
    tick();
    run_frame(-1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
